mul_mant_seq: RTL

//  Multi-cycle unsigned significand multiplier for the FP multiply path. Sits upstream of the

---
 rtl/mul_mant_seq_pkg.sv | 15 +
 rtl/mul_mant_seq_if.sv | 25 ++
 rtl/mul_mant_seq_ppgen.sv | 15 +
 rtl/mul_mant_seq.sv | 95 +++++++++
 4 files changed

// File: rtl/mul_mant_seq_pkg.sv
// Shared types and elaboration helpers for the sequential significand multiplier.
package mul_mant_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_seq_state_e;

  // Number of BUSY cycles needed to retire every multiplier bit.
  function automatic int unsigned iter_cnt(input int unsigned mant_w, input int unsigned bpc);
    return (mant_w + 1) / bpc;
  endfunction

endpackage

// File: rtl/mul_mant_seq_if.sv
// Operand/product handshake bundle between the FP multiply front end and mul_mant_seq.
interface mul_mant_seq_if #(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned SIDE_W = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_W:0]       a_sig;
  logic [MANT_W:0]       b_sig;
  logic [SIDE_W-1:0]     in_side;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*MANT_W+1:0]   mant_1;
  logic [SIDE_W-1:0]     out_side;

  modport master (
    output in_valid, a_sig, b_sig, in_side, out_ready,
    input  in_ready, out_valid, mant_1, out_side
  );

  modport slave (
    input  in_valid, a_sig, b_sig, in_side, out_ready,
    output in_ready, out_valid, mant_1, out_side
  );
endinterface

// File: rtl/mul_mant_seq_ppgen.sv
// Partial-product generator: multiplicand times one BPC-bit multiplier digit.
module mul_ppgen #(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned BPC    = 1
) (
  input  logic [MANT_W:0]     a_i,
  input  logic [BPC-1:0]      d_i,
  output logic [MANT_W+BPC:0] pp_o
);
  localparam int unsigned PP_W = MANT_W + BPC + 1;

  always_comb begin
    pp_o = PP_W'(a_i) * PP_W'(d_i);
  end
endmodule

// File: rtl/mul_mant_seq.sv
// Multi-cycle unsigned significand multiplier retiring BPC multiplier bits per cycle,
// with side-band carried alongside under a valid/ready handshake.
module mul_mant_seq
  import mul_mant_seq_pkg::*;
#(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned BPC    = 1,
  parameter int unsigned SIDE_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  mul_mant_seq_if.slave  bus
);
  localparam int unsigned SIG_W = MANT_W + 1;
  localparam int unsigned P_W   = 2 * SIG_W;
  localparam int unsigned PP_W  = SIG_W + BPC;
  localparam int unsigned ITER  = iter_cnt(MANT_W, BPC);
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  if ((SIG_W % BPC) != 0) begin : g_bpc_check
    $fatal(1, "mul_mant_seq: BPC must divide MANT_W+1");
  end

  logic [1:0]        state_q, state_d;
  logic [MANT_W:0]   a_q;
  logic [MANT_W:0]   b_q;
  logic [SIDE_W-1:0] side_q;
  logic [P_W-1:0]    acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PP_W-1:0]   pp;
  logic [P_W-1:0]    pp_sh;
  logic              accept;
  logic              zero_op;
  logic              last_iter;

  mul_ppgen #(
    .MANT_W (MANT_W),
    .BPC    (BPC)
  ) u_ppgen (
    .a_i  (a_q),
    .d_i  (b_q[BPC-1:0]),
    .pp_o (pp)
  );

  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign zero_op   = (bus.a_sig == '0) || (bus.b_sig == '0);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign pp_sh     = P_W'(pp) << (32'(cnt_q) * BPC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = zero_op ? S_DONE : S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      side_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= bus.a_sig;
        b_q    <= bus.b_sig;
        side_q <= bus.in_side;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_BUSY) begin
        // Final sum fits in P_W bits, so truncating each partial add is lossless.
        acc_q <= acc_q + pp_sh;
        b_q   <= b_q >> BPC;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.mant_1    = acc_q;
  assign bus.out_side  = side_q;

endmodule
